// File: rtl/sccb_ov5640_master.sv
// SCCB 3-phase write master for OV5640 register configuration: DEV_ID, addr hi, addr lo, data.
// Optional ACK checking with early STOP is enabled by defining SCCB_ACK_CHECK_EN.
module sccb_ov5640_master #(
    parameter int unsigned CLK_FREQ_HZ  = 50_000_000,
    parameter int unsigned SCCB_FREQ_HZ = 100_000,
    parameter logic [7:0]  DEV_ID       = 8'h78,
    parameter int unsigned GAP_QUARTERS = 4
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] address,
    input  logic [7:0]  data,
    output logic        ready,
    output logic        busy,
    output logic        sio_c,
    output logic        sio_d_oe,
    input  logic        sio_d_in,
    output logic        nack_err
);

    localparam int unsigned DIV = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ);
    localparam int unsigned DW  = (DIV < 2) ? 1 : $clog2(DIV);
    localparam int unsigned GW  = (GAP_QUARTERS < 2) ? 1 : $clog2(GAP_QUARTERS);

    if (DIV < 2) begin : g_div_check
        $error("sccb_ov5640_master: CLK_FREQ_HZ/(4*SCCB_FREQ_HZ) must be at least 2");
    end

    typedef enum logic [2:0] {StArm, StListen, StStart, StByte, StStop, StGap} state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   div_q, div_d;
    logic [1:0]      qtr_q, qtr_d;
    logic [3:0]      bit_q, bit_d;
    logic [1:0]      byte_q, byte_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [31:0]     shift_q, shift_d;
    logic            ready_d, busy_d, sio_c_d, oe_d;
    logic            tick, tx_bit, ack_fail;
    logic [4:0]      bit_idx;

    assign tick = (div_q == DW'(DIV - 1));

`ifdef SCCB_ACK_CHECK_EN
    logic nack_q;

    // Slave left SIO_D high during the ACK slot of the current byte.
    assign ack_fail = tick && (state_q == StByte) && (qtr_q == 2'd3) && (bit_q == 4'd8)
                      && sio_d_in;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            nack_q <= 1'b0;
        end else begin
            nack_q <= ack_fail;
        end
    end

    assign nack_err = nack_q;
`else
    logic unused_sio_d_in;

    assign unused_sio_d_in = sio_d_in;
    assign ack_fail        = 1'b0;
    assign nack_err        = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        qtr_d   = qtr_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        gap_d   = gap_q;
        shift_d = shift_q;
        // Free-running quarter divider, realigned whenever LISTEN is left.
        div_d   = (state_q == StListen || tick) ? '0 : div_q + 1'b1;
        unique case (state_q)
            StArm: state_d = StListen;
            StListen: begin
                if (start) begin
                    shift_d = {DEV_ID, address, data};
                    qtr_d   = '0;
                    bit_d   = '0;
                    byte_d  = '0;
                    state_d = StStart;
                end else begin
                    state_d = StArm;
                end
            end
            StStart: begin
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd3) state_d = StByte;
                end
            end
            StByte: begin
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd3) begin
                        if (bit_q == 4'd8) begin
                            bit_d = '0;
                            if (byte_q == 2'd3 || ack_fail) begin
                                byte_d  = '0;
                                state_d = StStop;
                            end else begin
                                byte_d = byte_q + 2'd1;
                            end
                        end else begin
                            bit_d = bit_q + 4'd1;
                        end
                    end
                end
            end
            StStop: begin
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd3) begin
                        gap_d   = '0;
                        state_d = (GAP_QUARTERS == 0) ? StArm : StGap;
                    end
                end
            end
            StGap: begin
                if (tick) begin
                    if (gap_q == GW'(GAP_QUARTERS - 1)) state_d = StArm;
                    else gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = StArm;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    assign bit_idx = {byte_d, bit_d[2:0]};
    assign tx_bit  = shift_q[~bit_idx];

    always_comb begin
        sio_c_d = 1'b1;
        oe_d    = 1'b0;
        case (state_d)
            StStart: begin
                sio_c_d = (qtr_d != 2'd3);
                oe_d    = (qtr_d != 2'd0);
            end
            StByte: begin
                sio_c_d = qtr_d[1];
                oe_d    = (bit_d != 4'd8) && !tx_bit;
            end
            StStop: begin
                sio_c_d = (qtr_d != 2'd0);
                oe_d    = !qtr_d[1];
            end
            default: ;
        endcase
        ready_d = (state_d == StArm);
        busy_d  = (state_d != StArm) && (state_d != StListen);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StArm;
            div_q    <= '0;
            qtr_q    <= '0;
            bit_q    <= '0;
            byte_q   <= '0;
            gap_q    <= '0;
            shift_q  <= '0;
            ready    <= 1'b0;
            busy     <= 1'b0;
            sio_c    <= 1'b1;
            sio_d_oe <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            qtr_q    <= qtr_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            gap_q    <= gap_d;
            shift_q  <= shift_d;
            ready    <= ready_d;
            busy     <= busy_d;
            sio_c    <= sio_c_d;
            sio_d_oe <= oe_d;
        end
    end

endmodule
